// File: rtl/game_scoreboard.sv
// Round timer, per-player BCD scores and persistent high score for the game cores.
// All values are registered packed BCD digits for direct hex_decoder use.
module game_scoreboard #(
  parameter int unsigned NUM_PLAYERS  = 2,
  parameter int unsigned SCORE_DIGITS = 2,
  parameter int unsigned TIME_DIGITS  = 4,
  parameter int unsigned TICK_CYCLES  = 50000000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic                                 game_over,
  input  logic                                 game_mode,
  input  logic [NUM_PLAYERS-1:0]               score_inc,
  output logic [TIME_DIGITS*4-1:0]             time_bcd,
  output logic [NUM_PLAYERS*SCORE_DIGITS*4-1:0] score_bcd,
  output logic [SCORE_DIGITS*4-1:0]            high_bcd,
  output logic                                 running,
  output logic                                 new_high
);

  localparam int unsigned SW = SCORE_DIGITS * 4;
  localparam int unsigned TW = TIME_DIGITS * 4;
  localparam int unsigned PW = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [TW-1:0] TIME_MAX  = {TIME_DIGITS{4'h9}};
  localparam logic [SW-1:0] SCORE_MAX = {SCORE_DIGITS{4'h9}};

  typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

  state_t                      state;
  logic [PW-1:0]               presc;
  logic                        tick;
  logic [TW-1:0]               time_next;
  logic [NUM_PLAYERS*SW-1:0]   score_next;
  logic [SW-1:0]               p0_score;
  logic                        t_carry;
  logic                        s_carry;

  assign tick     = (presc == PW'(TICK_CYCLES - 1));
  assign p0_score = score_bcd[SW-1:0];

  // Saturating BCD increments: an all-9s value is left untouched.
  always_comb begin
    time_next = time_bcd;
    t_carry   = 1'b1;
    if (time_bcd != TIME_MAX) begin
      for (int unsigned i = 0; i < TIME_DIGITS; i++) begin
        if (t_carry) begin
          if (time_bcd[i*4 +: 4] == 4'd9) begin
            time_next[i*4 +: 4] = '0;
          end else begin
            time_next[i*4 +: 4] = time_bcd[i*4 +: 4] + 4'd1;
            t_carry = 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    score_next = score_bcd;
    s_carry    = 1'b0;
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      s_carry = score_inc[p] && (score_bcd[p*SW +: SW] != SCORE_MAX);
      for (int unsigned i = 0; i < SCORE_DIGITS; i++) begin
        if (s_carry) begin
          if (score_bcd[p*SW + i*4 +: 4] == 4'd9) begin
            score_next[p*SW + i*4 +: 4] = '0;
          end else begin
            score_next[p*SW + i*4 +: 4] = score_bcd[p*SW + i*4 +: 4] + 4'd1;
            s_carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      presc     <= '0;
      time_bcd  <= '0;
      score_bcd <= '0;
      high_bcd  <= '0;
      running   <= 1'b0;
      new_high  <= 1'b0;
    end else begin
      case (state)
        IDLE, OVER: begin
          if (start) begin
            state     <= RUN;
            running   <= 1'b1;
            new_high  <= 1'b0;
            presc     <= '0;
            time_bcd  <= '0;
            score_bcd <= '0;
          end
        end
        RUN: begin
          // game_over outranks start here, and freezes this cycle's ticks and increments.
          if (game_over) begin
            state   <= OVER;
            running <= 1'b0;
            if (!game_mode && (p0_score > high_bcd)) begin
              high_bcd <= p0_score;
              new_high <= 1'b1;
            end
          end else begin
            presc     <= tick ? '0 : presc + PW'(1);
            score_bcd <= score_next;
            if (tick) time_bcd <= time_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_scoreboard.sv
// Self-checking bench for game_scoreboard: directed round scenarios followed by
// random traffic, compared against an integer reference model of the game rules.
module tb_game_scoreboard;

  localparam int NP   = 2;
  localparam int SD   = 2;
  localparam int TD   = 4;
  localparam int TK   = 4;
  localparam int SMAX = 99;
  localparam int TMAX = 9999;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic               game_over = 1'b0;
  logic               game_mode = 1'b0;
  logic [NP-1:0]      score_inc = '0;
  logic [TD*4-1:0]    time_bcd;
  logic [NP*SD*4-1:0] score_bcd;
  logic [SD*4-1:0]    high_bcd;
  logic               running;
  logic               new_high;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 idle, 1 run, 2 over; values kept as plain integers.
  int m_state;
  int m_rc;
  int m_sc[NP];
  int m_hi;
  bit m_nh;

  always #5 clk = ~clk;

  game_scoreboard #(
    .NUM_PLAYERS (NP),
    .SCORE_DIGITS(SD),
    .TIME_DIGITS (TD),
    .TICK_CYCLES (TK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .game_over(game_over),
    .game_mode(game_mode),
    .score_inc(score_inc),
    .time_bcd (time_bcd),
    .score_bcd(score_bcd),
    .high_bcd (high_bcd),
    .running  (running),
    .new_high (new_high)
  );

  function automatic logic [31:0] to_bcd(input int v);
    logic [31:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 8; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_rc    = 0;
    m_hi    = 0;
    m_nh    = 1'b0;
    for (int p = 0; p < NP; p++) m_sc[p] = 0;
  endtask

  task automatic model_edge();
    if (m_state == 1) begin
      if (game_over) begin
        m_state = 2;
        if (!game_mode && m_sc[0] > m_hi) begin
          m_hi = m_sc[0];
          m_nh = 1'b1;
        end
      end else begin
        m_rc++;
        for (int p = 0; p < NP; p++)
          if (score_inc[p] && m_sc[p] < SMAX) m_sc[p]++;
      end
    end else if (start) begin
      m_state = 1;
      m_rc    = 0;
      m_nh    = 1'b0;
      for (int p = 0; p < NP; p++) m_sc[p] = 0;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_all();
    int t;
    t = m_rc / TK;
    if (t > TMAX) t = TMAX;
    chk("running", 32'(running), 32'(m_state == 1));
    chk("new_high", 32'(new_high), 32'(m_nh));
    chk("time", 32'(time_bcd), to_bcd(t));
    for (int p = 0; p < NP; p++)
      chk($sformatf("score%0d", p), 32'(score_bcd[p*SD*4 +: SD*4]), to_bcd(m_sc[p]));
    chk("high", 32'(high_bcd), to_bcd(m_hi));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_all();
  endtask

  task automatic inc_n(input logic [NP-1:0] mask, input int n);
    for (int i = 0; i < n; i++) begin
      score_inc = mask;
      cycle();
      check_all();
    end
    score_inc = '0;
  endtask

  task automatic end_round(input logic mode);
    game_mode = mode;
    game_over = 1'b1;
    cycle();
    game_over = 1'b0;
    score_inc = '0;
    check_all();
  endtask

  initial begin
    model_reset();
    #1 reset = 1'b0;
    #1 check_all();
    @(negedge clk) reset = 1'b1;
    cycle(); check_all();
    cycle(); check_all();

    // Timer: first tick TK cycles after running rises, 0x0010 after 40.
    pulse_start();
    chk("running_rise", 32'(running), 32'd1);
    for (int i = 1; i <= 40; i++) begin
      cycle();
      check_all();
      if (i == 3) chk("time_before_tick", 32'(time_bcd), 32'h0000);
      if (i == 4) chk("time_first_tick", 32'(time_bcd), 32'h0001);
    end
    chk("time_40", 32'(time_bcd), 32'h0010);

    // Score carry then saturation.
    inc_n(2'b01, 12);
    chk("score_carry", 32'(score_bcd[7:0]), 32'h12);
    inc_n(2'b01, 100);
    chk("score_sat", 32'(score_bcd[7:0]), 32'h99);
    end_round(1'b1);

    // Concurrent increments.
    pulse_start();
    inc_n(2'b11, 3);
    chk("both_p0", 32'(score_bcd[7:0]), 32'h03);
    chk("both_p1", 32'(score_bcd[15:8]), 32'h03);
    end_round(1'b1);

    // Snake high score: set, then not beaten.
    pulse_start();
    inc_n(2'b01, 7);
    end_round(1'b0);
    chk("high_set", 32'(high_bcd), 32'h07);
    chk("new_high_set", 32'(new_high), 32'd1);
    pulse_start();
    chk("new_high_clr", 32'(new_high), 32'd0);
    inc_n(2'b01, 5);
    end_round(1'b0);
    chk("high_kept", 32'(high_bcd), 32'h07);
    chk("new_high_kept0", 32'(new_high), 32'd0);

    // Tron mode with an increment in the game_over cycle.
    pulse_start();
    inc_n(2'b01, 20);
    score_inc = 2'b01;
    end_round(1'b1);
    chk("tron_p0_frozen", 32'(score_bcd[7:0]), 32'h20);
    chk("tron_high", 32'(high_bcd), 32'h07);
    inc_n(2'b11, 4);
    chk("over_ignores_inc", 32'(score_bcd[7:0]), 32'h20);

    // Simultaneous start/game_over: in RUN game_over wins, in OVER start wins.
    pulse_start();
    inc_n(2'b10, 2);
    start = 1'b1; game_over = 1'b1; game_mode = 1'b0;
    cycle(); check_all();
    chk("run_go_wins", 32'(running), 32'd0);
    cycle(); check_all();
    chk("over_start_wins", 32'(running), 32'd1);
    start = 1'b0; game_over = 1'b0;

    // Asynchronous reset mid-round clears the high score too.
    inc_n(2'b01, 3);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all();
    chk("reset_high", 32'(high_bcd), 32'h00);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      score_inc = 2'b11;
      game_over = 1'b1;
      cycle();
      check_all();
    end
    score_inc = '0;
    game_over = 1'b0;
    chk("idle_after_reset", 32'(running), 32'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      start     = ($urandom_range(0, 19) == 0);
      game_over = ($urandom_range(0, 24) == 0);
      game_mode = 1'($urandom_range(0, 1));
      score_inc = NP'($urandom);
      cycle();
      check_all();
    end
    start = 1'b0; game_over = 1'b0; score_inc = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
